remote_cmd_seq: RTL and testbench
=================================

Name: remote_cmd_seq

Overview:
Parametrised host-command sequencer that replaces hand-scripted send/wait/check stimulus with a buffered, self-checking command engine. It queues up to DEPTH {cmd, data} pairs and drives them one at a time into a RemoteComm-style UART master through its send_cmd/cmd_sent/resp_rdy/clr_resp_rdy handshake. Each response is checked against the acknowledge byte, with timeout and bounded retry. It sits between a host-side controller (or bench) and the UART master that talks to the QuadCopter RX/TX pins.

Parameters:
DEPTH, 8, command FIFO entries (power of 2, >=2)
ACK_BYTE, 8'hA5, expected positive response
TIMEOUT, 2000000, clk cycles allowed from send_cmd to resp_rdy before a timeout
MAX_RETRY, 2, resends after the first attempt before declaring an error

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
push  in  1  enqueue {push_cmd, push_data} this cycle
push_cmd  in  8  command opcode (02 ptch, 03 roll, 04 yaw, 05 thrst, 06 cal, 07 emer_land, 08 mtrs_off)
push_data  in  16  command data
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH+1)  entries queued, including the one in flight
cmd  out  8  opcode to UART master
data  out  16  data to UART master
send_cmd  out  1  one-cycle start pulse to UART master
cmd_sent  in  1  UART master finished transmitting
resp_rdy  in  1  response byte valid
resp  in  8  response byte
clr_resp_rdy  out  1  one-cycle pulse that knocks down resp_rdy
busy  out  1  state != IDLE
acked  out  1  one-cycle pulse when the head command receives ACK_BYTE
err  out  1  sticky failure flag
err_cmd  out  8  opcode that exhausted its retries
clr_err  in  1  acknowledge an error and discard the failed entry

Behaviour:
- Reset (rst_n low at posedge): FIFO emptied, state IDLE. Outputs: send_cmd=0, clr_resp_rdy=0, acked=0, err=0, err_cmd=0, cmd=0, data=0, empty=1, full=0, count=0. A reset during any state aborts the transfer with no pulses emitted.
- FIFO: push while full is ignored, and contents are unchanged. This holds even when a pop occurs in the same cycle. A pop (head removal) occurs only on ACK or on clr_err. When push and pop happen in the same non-full cycle, count stays the same. Pointers wrap modulo DEPTH.
- cmd/data always show the head entry while it is in flight, and stay stable from SEND until the entry is popped.
- FSM:
  - IDLE: if !empty, go to SEND.
  - SEND: send_cmd=1 for exactly one cycle; clear timer; go to WAIT_SENT.
  - WAIT_SENT: wait for cmd_sent=1, then go to WAIT_RESP. The timer runs.
  - WAIT_RESP: wait for resp_rdy=1, then go to CHECK. The timer runs. If the timer reaches TIMEOUT in WAIT_SENT or WAIT_RESP, go to FAIL.
  - CHECK: clr_resp_rdy=1 for one cycle.
    - resp==ACK_BYTE: acked=1, pop, clear retry count, go to IDLE.
    - Otherwise (NACK): go to FAIL.
  - FAIL: if retry_cnt < MAX_RETRY, increment retry_cnt and go to SEND (same entry resent). Otherwise set err=1 and err_cmd=head cmd, then go to HALT.
  - HALT: no traffic; push is still accepted. On clr_err=1: err=0, pop the failed entry, clear retry_cnt, go to IDLE. err_cmd holds its value until the next error.
- Latency: push into an empty idle block gives send_cmd two cycles later (IDLE→SEND). ACK in CHECK lets the next send_cmd start 2 cycles after acked.
- Total attempts per entry = 1 + MAX_RETRY. The timer is $clog2(TIMEOUT+1) bits and saturates.
- clr_err outside HALT is ignored. A resp_rdy that arrives while in WAIT_SENT is held by the UART master and serviced after cmd_sent.

Optional Feature:
Macro CMD_SEQ_STATS_EN.
- Defined: adds outputs ack_cnt[15:0], nack_cnt[15:0] and tmo_cnt[15:0], all saturating and cleared by reset.
  - ack_cnt increments on each acked pulse.
  - nack_cnt increments on each CHECK that sees a non-ACK byte.
  - tmo_cnt increments on each timeout.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push 05/00FF, 02/0100, 03/FF80, 04/0080; model returns A5 each time → four send_cmd pulses in push order with matching cmd/data, four acked pulses, empty=1, err=0.
- Push DEPTH+1 entries while the model stalls cmd_sent → full=1 after DEPTH pushes, count=DEPTH, extra entry dropped; after release, exactly DEPTH commands are sent.
- Model returns 0x5A once, then A5 for cmd 06 → two send_cmd for 06, one clr_resp_rdy per response, single acked, err=0.
- Model never asserts resp_rdy for cmd 08 with TIMEOUT=100, MAX_RETRY=2 → three send_cmd pulses about 100 cycles apart, then err=1 and err_cmd=08; after clr_err the entry is dropped and the next queued command is sent.
- Assert rst_n=0 in WAIT_RESP with 3 entries queued → next cycle: busy=0, count=0, err=0, no clr_resp_rdy pulse.
- With CMD_SEQ_STATS_EN: one NACK, one timeout, two ACKs → nack_cnt=1, tmo_cnt=1, ack_cnt=2.

Source files
------------

// File: rtl/remote_cmd_seq.sv
// remote_cmd_seq: buffered command sequencer for a RemoteComm-style UART master.
// Queues {cmd,data} pairs, sends them one at a time, checks ACK, retries, flags errors.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   push/push_cmd/data   enqueue a command (dropped when full)
//   full/empty/count     FIFO status (count includes in-flight entry)
//   cmd/data/send_cmd    command to UART master, one-cycle start pulse
//   cmd_sent             UART master finished transmitting
//   resp_rdy/resp        response byte valid / value
//   clr_resp_rdy         one-cycle pulse to knock down resp_rdy
//   busy/acked           FSM not idle / head command acknowledged
//   err/err_cmd/clr_err  sticky failure, failed opcode, acknowledge+drop
// Optional macro CMD_SEQ_STATS_EN adds ack_cnt/nack_cnt/tmo_cnt.

module remote_cmd_seq #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] ACK_BYTE  = 8'hA5,
  parameter int         TIMEOUT   = 2000000,
  parameter int         MAX_RETRY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_cmd,
  input  logic [15:0]                push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 cmd,
  output logic [15:0]                data,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       clr_resp_rdy,
  output logic                       busy,
  output logic                       acked,
  output logic                       err,
  output logic [7:0]                 err_cmd,
  input  logic                       clr_err
`ifdef CMD_SEQ_STATS_EN
  ,
  output logic [15:0]                ack_cnt,
  output logic [15:0]                nack_cnt,
  output logic [15:0]                tmo_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY+1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_CNT  = TW'(TIMEOUT);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    CHECK,
    FAIL,
    HALT
  } state_t;

  state_t state_q, state_d;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] retry_q;
  logic [7:0]    cmd_q;
  logic [15:0]   data_q;
  logic          err_q;
  logic [7:0]    err_cmd_q;

  logic is_ack;
  logic tmo_hit;
  logic give_up;
  logic do_push;
  logic do_pop;
  logic tmo_evt;
  logic in_wait;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign cmd     = cmd_q;
  assign data    = data_q;
  assign err     = err_q;
  assign err_cmd = err_cmd_q;
  assign busy    = (state_q != IDLE);

  assign is_ack  = (resp == ACK_BYTE);
  assign tmo_hit = (timer_q >= TMO_CNT);
  assign give_up = (retry_q >= RTY_MAX);
  assign in_wait = (state_q == WAIT_SENT) ||
                   (state_q == WAIT_RESP);

  // Pulses are gated by rst_n so a reset cycle never leaks one.
  assign send_cmd     = rst_n && (state_q == SEND);
  assign clr_resp_rdy = rst_n && (state_q == CHECK);
  assign acked        = clr_resp_rdy && is_ack;

  assign do_push = rst_n && push && !full;
  assign do_pop  = acked ||
                   (rst_n && (state_q == HALT) && clr_err);

  // Timeout only counts when the awaited event did not arrive.
  assign tmo_evt = rst_n && tmo_hit &&
    (((state_q == WAIT_SENT) && !cmd_sent) ||
     ((state_q == WAIT_RESP) && !resp_rdy));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty) state_d = SEND;
      SEND:      state_d = WAIT_SENT;
      WAIT_SENT: begin
        if (cmd_sent)     state_d = WAIT_RESP;
        else if (tmo_hit) state_d = FAIL;
      end
      WAIT_RESP: begin
        if (resp_rdy)     state_d = CHECK;
        else if (tmo_hit) state_d = FAIL;
      end
      CHECK:     state_d = is_ack ? IDLE : FAIL;
      FAIL:      state_d = give_up ? HALT : SEND;
      HALT:      if (clr_err) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_cmd, push_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      retry_q   <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cmd_q <= '0;
    end else begin
      state_q <= state_d;

      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (state_q == SEND)
        timer_q <= '0;
      else if (in_wait && !tmo_hit)
        timer_q <= timer_q + TW'(1);

      if ((state_q == FAIL) && !give_up)
        retry_q <= retry_q + RW'(1);
      else if (do_pop)
        retry_q <= '0;

      // Latch the head once so cmd/data stay put until popped.
      if ((state_q == IDLE) && !empty)
        {cmd_q, data_q} <= mem[rd_ptr];

      if ((state_q == FAIL) && give_up) begin
        err_q     <= 1'b1;
        err_cmd_q <= cmd_q;
      end else if ((state_q == HALT) && clr_err) begin
        err_q     <= 1'b0;
      end
    end
  end

`ifdef CMD_SEQ_STATS_EN
  logic nack_evt;
  assign nack_evt = clr_resp_rdy && !is_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_cnt  <= '0;
      nack_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (acked && (ack_cnt != 16'hFFFF))
        ack_cnt <= ack_cnt + 16'd1;
      if (nack_evt && (nack_cnt != 16'hFFFF))
        nack_cnt <= nack_cnt + 16'd1;
      if (tmo_evt && (tmo_cnt != 16'hFFFF))
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = tmo_evt;
`endif

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb_remote_cmd_seq: directed + randomized bench for remote_cmd_seq.
// A UART-master model answers from a per-attempt script.

module tb_remote_cmd_seq;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;

  logic        clk = 0;
  logic        rst_n;
  logic        push;
  logic [7:0]  push_cmd;
  logic [15:0] push_data;
  logic        full, empty;
  logic [3:0]  count;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;
  logic        busy, acked, err;
  logic [7:0]  err_cmd;
  logic        clr_err;
`ifdef CMD_SEQ_STATS_EN
  logic [15:0] ack_cnt, nack_cnt, tmo_cnt;
`endif

  remote_cmd_seq #(
    .DEPTH(DEPTH), .ACK_BYTE(8'hA5),
    .TIMEOUT(TMO), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .push_cmd(push_cmd),
    .push_data(push_data),
    .full(full), .empty(empty), .count(count),
    .cmd(cmd), .data(data), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy),
    .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .busy(busy), .acked(acked), .err(err),
    .err_cmd(err_cmd), .clr_err(clr_err)
`ifdef CMD_SEQ_STATS_EN
    ,
    .ack_cnt(ack_cnt), .nack_cnt(nack_cnt),
    .tmo_cnt(tmo_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Script entry per attempt: 0..255 = byte to answer, -1 = silent.
  int          script[$];
  logic [23:0] sent_q[$];
  int          send_t[$];
  logic [7:0]  acked_q[$];
  logic [7:0]  exp_errs[$];
  int          n_clr = 0;
  bit          stall_sent = 0;

  int cyc = 0;
  int ph  = 0;
  int dly = 0;
  int cur = 0;

  // UART master model, driven away from the DUT's sampling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cmd_sent = 0;
      resp_rdy = 0;
      resp     = 0;
      ph       = 0;
    end else begin
      cmd_sent = 0;
      if (clr_resp_rdy) begin
        resp_rdy = 0;
        n_clr++;
      end
      if (acked) acked_q.push_back(cmd);
      case (ph)
        0: if (send_cmd) begin
          sent_q.push_back({cmd, data});
          send_t.push_back(cyc);
          if (script.size() > 0) cur = script.pop_front();
          else cur = 32'hA5;
          dly = $urandom_range(1, 4);
          ph  = 1;
        end
        1: if (!stall_sent) begin
          if (dly == 0) begin
            cmd_sent = 1;
            dly = $urandom_range(0, 3);
            ph  = 2;
          end else dly--;
        end
        2: if (dly == 0) begin
          if (cur >= 0) begin
            resp_rdy = 1;
            resp     = cur[7:0];
          end
          ph = 0;
        end else dly--;
        default: ph = 0;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [7:0] c,
                         input logic [15:0] d);
    push      = 1;
    push_cmd  = c;
    push_data = d;
    @(negedge clk);
    push = 0;
  endtask

  task automatic clear_logs();
    sent_q.delete();
    send_t.delete();
    acked_q.delete();
    exp_errs.delete();
    script.delete();
    n_clr = 0;
  endtask

  // Run until drained; services errors by checking err_cmd and clr_err.
  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (err) begin
        if (exp_errs.size() > 0)
          chk("err_cmd", {24'd0, err_cmd},
              {24'd0, exp_errs.pop_front()});
        else
          chk("unexp_err", 32'(err), 32'd0);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
      end else if (empty && !busy) begin
        done = 1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $error("FAIL wait_idle observed=busy expected=idle");
    end
  endtask

  logic [23:0] exp_s[$];
  logic [7:0]  exp_a[$];

  initial begin
    int d;
    rst_n     = 0;
    push      = 0;
    push_cmd  = 0;
    push_data = 0;
    clr_err   = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Reset state
    chk("rst_send", 32'(send_cmd), 0);
    chk("rst_clr", 32'(clr_resp_rdy), 0);
    chk("rst_acked", 32'(acked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_errcmd", 32'(err_cmd), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);

    // Four ACKed commands, with push->send latency
    clear_logs();
    do_push(8'h05, 16'h00FF);
    chk("lat_c1", 32'(send_cmd), 0);
    @(negedge clk);
    chk("lat_c2", 32'(send_cmd), 1);
    do_push(8'h02, 16'h0100);
    do_push(8'h03, 16'hFF80);
    do_push(8'h04, 16'h0080);
    wait_idle(2000);
    exp_s = '{24'h0500FF, 24'h020100,
              24'h03FF80, 24'h040080};
    chk("ack4_nsent", sent_q.size(), 4);
    for (int i = 0; i < 4 && i < sent_q.size(); i++)
      chk("ack4_sent", 32'(sent_q[i]), 32'(exp_s[i]));
    chk("ack4_nacked", acked_q.size(), 4);
    for (int i = 0; i < 4 && i < acked_q.size(); i++)
      chk("ack4_acked", 32'(acked_q[i]),
          32'(exp_s[i][23:16]));
    chk("ack4_nclr", n_clr, 4);
    chk("ack4_empty", 32'(empty), 1);
    chk("ack4_err", 32'(err), 0);

    // Fill past DEPTH while cmd_sent is stalled
    clear_logs();
    stall_sent = 1;
    for (int i = 0; i <= DEPTH; i++)
      do_push(8'(2 + i % 7), 16'(16'h1000 + i));
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), DEPTH);
    stall_sent = 0;
    wait_idle(3000);
    chk("full_nsent", sent_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < sent_q.size(); i++)
      chk("full_sent", 32'(sent_q[i]),
          32'({8'(2 + i % 7), 16'(16'h1000 + i)}));
    chk("full_empty", 32'(empty), 1);

    // One NACK then ACK
    clear_logs();
    script = '{32'h5A, 32'hA5};
    do_push(8'h06, 16'h1234);
    wait_idle(2000);
    chk("nack_nsent", sent_q.size(), 2);
    for (int i = 0; i < 2 && i < sent_q.size(); i++)
      chk("nack_sent", 32'(sent_q[i]), 32'h061234);
    chk("nack_nclr", n_clr, 2);
    chk("nack_nacked", acked_q.size(), 1);
    chk("nack_err", 32'(err), 0);

    // Three timeouts -> error, drop, next command proceeds
    clear_logs();
    script = '{-1, -1, -1};
    exp_errs.push_back(8'h08);
    do_push(8'h08, 16'h0000);
    do_push(8'h02, 16'h0042);
    wait_idle(3000);
    chk("tmo_nsent", sent_q.size(), 4);
    for (int i = 0; i < 3 && i < sent_q.size(); i++)
      chk("tmo_sent08", 32'(sent_q[i]), 32'h080000);
    if (sent_q.size() == 4)
      chk("tmo_next", 32'(sent_q[3]), 32'h020042);
    for (int i = 1; i < 3 && i < send_t.size(); i++) begin
      d = send_t[i] - send_t[i-1];
      chk("tmo_gap", 32'(d >= TMO && d <= TMO + 6), 1);
    end
    chk("tmo_errs_left", exp_errs.size(), 0);
    chk("tmo_err_clr", 32'(err), 0);
    chk("tmo_errcmd_hold", 32'(err_cmd), 32'h08);
    chk("tmo_nacked", acked_q.size(), 1);

    // Reset while waiting for a response
    clear_logs();
    script = '{-1};
    do_push(8'h03, 16'h0001);
    do_push(8'h04, 16'h0002);
    do_push(8'h05, 16'h0003);
    repeat (20) @(negedge clk);
    chk("prerst_busy", 32'(busy), 1);
    rst_n = 0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_clr", 32'(clr_resp_rdy), 0);
    chk("mrst_nclr", n_clr, 0);
    rst_n = 1;
    @(negedge clk);
    chk("mrst_empty", 32'(empty), 1);

`ifdef CMD_SEQ_STATS_EN
    // Stats: one NACK, one timeout, two ACKs
    clear_logs();
    script = '{32'h33, -1, 32'hA5};
    do_push(8'h05, 16'h0001);
    do_push(8'h03, 16'h0002);
    wait_idle(2000);
    chk("st_nack", 32'(nack_cnt), 1);
    chk("st_tmo", 32'(tmo_cnt), 1);
    chk("st_ack", 32'(ack_cnt), 2);
`endif

    // Randomized rounds against a per-entry outcome model
    for (int r = 0; r < 8; r++) begin
      int k;
      logic [7:0]  rc[4];
      logic [15:0] rd[4];
      clear_logs();
      exp_s.delete();
      exp_a.delete();
      k = $urandom_range(1, 4);
      for (int e = 0; e < k; e++) begin
        rc[e] = 8'($urandom_range(2, 8));
        rd[e] = 16'($urandom);
        for (int a = 0; a < 3; a++) begin
          int o, b;
          o = $urandom_range(0, 9);
          exp_s.push_back({rc[e], rd[e]});
          if (o < 6) begin
            script.push_back(32'hA5);
            exp_a.push_back(rc[e]);
            break;
          end
          if (o < 8) begin
            b = $urandom_range(0, 255);
            if (b == 32'hA5) b = 0;
            script.push_back(b);
          end else begin
            script.push_back(-1);
          end
          if (a == 2) exp_errs.push_back(rc[e]);
        end
      end
      for (int e = 0; e < k; e++) do_push(rc[e], rd[e]);
      wait_idle(5000);
      chk("rnd_nsent", sent_q.size(), exp_s.size());
      for (int i = 0; i < exp_s.size() &&
           i < sent_q.size(); i++)
        chk("rnd_sent", 32'(sent_q[i]), 32'(exp_s[i]));
      chk("rnd_nacked", acked_q.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() &&
           i < acked_q.size(); i++)
        chk("rnd_acked", 32'(acked_q[i]), 32'(exp_a[i]));
      chk("rnd_errs_left", exp_errs.size(), 0);
      chk("rnd_err", 32'(err), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
